// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor.
// Runs on the board reference clock, pulses the PLL reset, synchronises the
// asynchronous lock indication and holds the system in reset until lock has
// been continuously present for a programmed number of cycles. Timeouts while
// waiting for lock and losses of lock while running are counted (saturating).
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int CNT_W          = 16,
  parameter int STAT_W         = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] retry_count,
  output logic [STAT_W-1:0] loss_count
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Terminal values of the shared cycle counter for each timed phase.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_ONE    = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [STAT_W-1:0] retry_nxt, loss_nxt;
  logic              pll_rst_nxt, sys_rst_nxt, ready_nxt;
  logic              locked_meta, locked_s;

  // Two-flop synchroniser bringing the PLL lock flag into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  // State, counter, status counters and registered outputs all update together.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      retry_count <= retry_nxt;
      loss_count  <= loss_nxt;
      pll_rst     <= pll_rst_nxt;
      sys_rst     <= sys_rst_nxt;
      ready       <= ready_nxt;
    end
  end

  // Next-state logic: phase timing, lock qualification and event counting.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    retry_nxt = retry_count;
    loss_nxt  = loss_count;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          if (retry_count != STAT_MAX) begin
            retry_nxt = retry_count + STAT_ONE;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          if (loss_count != STAT_MAX) begin
            loss_nxt = loss_count + STAT_ONE;
          end
        end
      end
      default: begin
        state_nxt = ST_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs register alongside the state.
  always_comb begin
    pll_rst_nxt = (state_nxt == ST_PLL_RST);
    sys_rst_nxt = (state_nxt != ST_RUN);
    ready_nxt   = (state_nxt == ST_RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed bring-up, timeout, glitch, loss,
// reset and saturation scenarios checked against a phase/timer model.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 100;
  localparam int LOCK_STABLE    = 8;
  localparam int CNT_W          = 16;
  localparam int STAT_W         = 2;
  localparam int STAT_MAX       = (1 << STAT_W) - 1;

  logic              refclk;
  logic              rst;
  logic              pll_locked;
  logic              pll_rst;
  logic              sys_rst;
  logic              ready;
  logic [1:0]        state;
  logic [STAT_W-1:0] retry_count;
  logic [STAT_W-1:0] loss_count;

  int assertions = 0;
  int failures   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .CNT_W         (CNT_W),
    .STAT_W        (STAT_W)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state      (state),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  // 50 MHz reference clock.
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs at a falling edge and hold them for n cycles.
  task automatic applyStimulus(input logic r, input logic l, input int n);
    rst        = r;
    pll_locked = l;
    repeat (n) @(negedge refclk);
  endtask

  // Model: the current phase (codes 0..3 as exposed on 'state'), cycles
  // already spent in it, and the lock flag as seen two edges late.
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_retry   = 0;
  int m_loss    = 0;
  bit m_valid   = 1'b0;
  int lock_hist[$] = '{0, 0};

  // Advance the model one reference edge using the inputs held since the last fall.
  always @(posedge refclk) begin
    int seen_lock;
    if (rst) begin
      m_phase   = 0;
      m_elapsed = 0;
      m_retry   = 0;
      m_loss    = 0;
      lock_hist = '{0, 0};
      m_valid   = 1'b1;
    end else begin
      seen_lock = lock_hist[0];
      case (m_phase)
        0: begin
          if (m_elapsed + 1 >= PLL_RST_CYCLES) begin m_phase = 1; m_elapsed = 0; end
          else m_elapsed++;
        end
        1: begin
          if (seen_lock != 0) begin m_phase = 2; m_elapsed = 0; end
          else if (m_elapsed + 1 >= LOCK_TIMEOUT) begin
            m_phase = 0; m_elapsed = 0;
            if (m_retry < STAT_MAX) m_retry++;
          end else m_elapsed++;
        end
        2: begin
          if (seen_lock == 0) begin m_phase = 1; m_elapsed = 0; end
          else if (m_elapsed + 1 >= LOCK_STABLE) m_phase = 3;
          else m_elapsed++;
        end
        default: begin
          if (seen_lock == 0) begin
            m_phase = 0; m_elapsed = 0;
            if (m_loss < STAT_MAX) m_loss++;
          end
        end
      endcase
      void'(lock_hist.pop_front());
      lock_hist.push_back(pll_locked ? 1 : 0);
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge refclk) begin
    if (m_valid) begin
      checkOutput("model_state", state, m_phase);
      checkOutput("model_pll_rst", pll_rst, (m_phase == 0) ? 1 : 0);
      checkOutput("model_sys_rst", sys_rst, (m_phase != 3) ? 1 : 0);
      checkOutput("model_ready", ready, (m_phase == 3) ? 1 : 0);
      checkOutput("model_retry", retry_count, m_retry);
      checkOutput("model_loss", loss_count, m_loss);
    end
  end

  // Hard stop in case a scenario wedges despite its own bounds.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_pll_rst"}, pll_rst, 1);
    checkOutput({tag, "_sys_rst"}, sys_rst, 1);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_retry"}, retry_count, 0);
    checkOutput({tag, "_loss"}, loss_count, 0);
  endtask

  // Count falling edges on which pll_rst reads high, starting now.
  task automatic measurePllRst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++;
      @(negedge refclk);
    end
  endtask

  // Count falling edges until ready is high.
  task automatic waitReady(input int budget, output int n);
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (ready !== 1'b1 && n < budget);
  endtask

  // Count falling edges until the state code equals target.
  task automatic waitState(input int target, input int budget, output int n);
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (state !== 2'(target) && n < budget);
  endtask

  initial begin
    int n;
    applyStimulus(1'b1, 1'b0, 3);
    checkResetValues("reset");

    // Clean bring-up.
    rst = 1'b0;
    measurePllRst(n);
    checkOutput("bringup_pll_rst_width", n, 4);
    applyStimulus(1'b0, 1'b0, 9);
    checkOutput("bringup_waiting", state, 1);
    pll_locked = 1'b1;
    // Release lands on edge k+2+LOCK_STABLE, k being the first edge after the rise.
    waitReady(60, n);
    checkOutput("bringup_release_edges", n, 11);
    checkOutput("bringup_sys_rst", sys_rst, 0);
    checkOutput("bringup_counters", {retry_count, loss_count}, 0);

    // Loss of lock in RUN, then a full re-sequence with lock already present.
    pll_locked = 1'b0;
    n = 0;
    do begin @(negedge refclk); n++; end while (sys_rst !== 1'b1 && n < 20);
    checkOutput("loss_latency_edges", n, 3);
    checkOutput("loss_state", state, 0);
    checkOutput("loss_ready", ready, 0);
    checkOutput("loss_count_one", loss_count, 1);
    pll_locked = 1'b1;
    waitReady(60, n);
    checkOutput("reseq_release_edges", n, 13);

    // Lock timeout retries.
    pll_locked = 1'b0;
    waitState(1, 30, n);
    checkOutput("timeout_enter_wait", state, 1);
    n = 0;
    do begin @(negedge refclk); n++; end while (pll_rst !== 1'b1 && n < 200);
    checkOutput("timeout_cycles", n, 100);
    checkOutput("timeout_retry_one", retry_count, 1);
    measurePllRst(n);
    checkOutput("timeout_pll_rst_width", n, 4);
    n = 0;
    do begin @(negedge refclk); n++; end while (retry_count !== 2'd3 && n < 400);
    checkOutput("third_timeout_edges", n, 204);
    checkOutput("timeout_retry_three", retry_count, 3);
    checkOutput("timeout_sys_rst", sys_rst, 1);

    // Acquisition glitch: 5 high, 1 low, then high.
    waitState(1, 20, n);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("glitch_in_stable", state, 2);
    applyStimulus(1'b0, 1'b0, 1);
    pll_locked = 1'b1;
    @(negedge refclk);
    @(negedge refclk);
    checkOutput("glitch_back_to_wait", state, 1);
    n = 2;
    do begin @(negedge refclk); n++; end while (ready !== 1'b1 && n < 60);
    checkOutput("glitch_release_edges", n, 11);
    checkOutput("glitch_no_loss", loss_count, 2);

    // Reset during RUN.
    applyStimulus(1'b1, 1'b1, 1);
    checkResetValues("rst_run");
    rst = 1'b0;
    measurePllRst(n);
    checkOutput("rst_run_pll_rst_width", n, 4);

    // Reset during STABLE.
    waitState(2, 40, n);
    checkOutput("reach_stable", state, 2);
    applyStimulus(1'b1, 1'b1, 1);
    checkResetValues("rst_stable");
    rst = 1'b0;
    measurePllRst(n);
    checkOutput("rst_stable_pll_rst_width", n, 4);
    waitReady(60, n);
    checkOutput("rst_stable_recovers", ready, 1);

    // Five losses saturate the 2-bit loss counter.
    for (int i = 0; i < 5; i++) begin
      pll_locked = 1'b0;
      waitState(0, 10, n);
      pll_locked = 1'b1;
      waitReady(60, n);
      checkOutput("sat_resync", ready, 1);
    end
    checkOutput("sat_loss_count", loss_count, 3);
    checkOutput("sat_retry_count", retry_count, 0);

    repeat (3) @(negedge refclk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Reset and lock supervisor paired with the 40 MHz PLL wrapper. It runs on the 50 MHz board reference clock, drives the PLL's reset input and synchronises the PLL's asynchronous locked output. It releases the system reset only after lock has stayed stable for a programmed time. It re-runs the PLL reset on lock timeout or loss of lock, and counts both events for status readout.

Parameters:
PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before PLL reset retry (1 ms at 50 MHz)
LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release
CNT_W, 16, width of the shared cycle counter; all three counts must be <= 2^CNT_W
STAT_W, 8, width of the status counters

Ports:
refclk  input  1  50 MHz reference clock, the only clock
rst  input  1  synchronous, active-high reset
pll_locked  input  1  PLL locked output, asynchronous to refclk
pll_rst  output  1  reset to the PLL, registered
sys_rst  output  1  system reset, registered, active-high; outclk-domain consumers re-synchronise it
ready  output  1  high only in RUN
state  output  2  current state code: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
retry_count  output  STAT_W  lock-timeout retries, saturating
loss_count  output  STAT_W  losses of lock from RUN, saturating

Behaviour:
- Locked synchroniser: two flops, locked_s = second stage. Both stages reset to 0.
- Outputs are registered and change on the same edge as the state. pll_rst=1 only in PLL_RST. sys_rst=0 and ready=1 only in RUN.
- Reset values (rst high at an edge): state=PLL_RST, cnt=0, pll_rst=1, sys_rst=1, ready=0, retry_count=0, loss_count=0, sync flops=0. rst takes priority over every transition.
- PLL_RST:
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
  - pll_rst is high for exactly PLL_RST_CYCLES edges after rst deasserts.
  - locked_s is ignored here.
- WAIT_LOCK:
  - If locked_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: go to PLL_RST, cnt=0, retry_count+1 (saturates at all-ones).
  - Else cnt+1.
  - If locked_s and the timeout occur on the same cycle, lock wins.
- STABLE:
  - If locked_s=0: go back to WAIT_LOCK, cnt=0. This is a glitch during acquisition; no counter increments.
  - Else if cnt==LOCK_STABLE-1: go to RUN.
  - Else cnt+1.
- RUN:
  - cnt holds.
  - If locked_s=0: go to PLL_RST, cnt=0, loss_count+1 (saturating). sys_rst=1 and ready=0 on that same edge.
- Latency:
  - pll_locked rising before edge k gives locked_s after edge k+1.
  - STABLE is entered at edge k+2.
  - RUN, with sys_rst falling, at edge k+2+LOCK_STABLE.
  - A drop of pll_locked in RUN asserts sys_rst at edge k+2 after sampling.
- Pulses on pll_locked shorter than one refclk period may be missed. This is acceptable.
- Status counters never wrap. They are cleared only by rst.

Test Plan:
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8.
1. Clean bring-up: release rst; raise pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 10 cycles after pll_locked rises (2 sync + 8 stable); counters stay 0.
2. Lock timeout: hold pll_locked=0 -> after 100 cycles in WAIT_LOCK, pll_rst re-pulses for 4 cycles; retry_count=1; after 3 timeouts retry_count=3; sys_rst stays 1 throughout.
3. Acquisition glitch: locked high 5 cycles, low 1 cycle, then high -> state returns to WAIT_LOCK; the stable count restarts; release occurs 10 cycles after the final rise; loss_count=0.
4. Loss in RUN: drop pll_locked in RUN -> 2 edges later sys_rst=1, ready=0, state=PLL_RST, loss_count=1; full re-sequence follows.
5. Saturation: with STAT_W=2, force 5 losses -> loss_count stays at 3.
6. Reset mid-operation: assert rst for 1 cycle during STABLE and during RUN -> next edge shows reset values; pll_rst is then high for 4 cycles.
